// File: rtl/all_set_arbiter.sv
// Two-requester round-robin arbiter that captures one byte per transaction and
// reports whether all bits are set, keeping a saturating all-set count per requester.
module all_set_arbiter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [7:0]       data0,
  input  logic             req1,
  input  logic [7:0]       data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             res_valid,
  output logic             res_id,
  output logic             res_all_set,
  output logic [CNT_W-1:0] set_cnt0,
  output logic [CNT_W-1:0] set_cnt1,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [7:0]       cap, cap_n;
  logic             win_id, win_id_n;
  logic             last, last_n;
  logic             win;
  logic             gnt0_n, gnt1_n, res_valid_n, res_id_n, res_all_set_n, busy_n;
  logic [CNT_W-1:0] set_cnt0_n, set_cnt1_n;

  // Tie goes to the requester not granted last time; a lone requester always wins.
  always_comb begin
    if (req0 && req1) win = ~last;
    else              win = req1;
  end

  always_comb begin
    state_n       = state;
    cap_n         = cap;
    win_id_n      = win_id;
    last_n        = last;
    gnt0_n        = 1'b0;
    gnt1_n        = 1'b0;
    res_valid_n   = 1'b0;
    res_id_n      = res_id;
    res_all_set_n = res_all_set;
    set_cnt0_n    = set_cnt0;
    set_cnt1_n    = set_cnt1;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          cap_n    = win ? data1 : data0;
          win_id_n = win;
          last_n   = win;
          gnt0_n   = ~win;
          gnt1_n   = win;
          state_n  = CHECK;
        end
      end
      CHECK: begin
        res_valid_n   = 1'b1;
        res_id_n      = win_id;
        res_all_set_n = &cap;
        state_n       = DONE;
      end
      DONE: begin
        if (res_all_set) begin
          if (!res_id && set_cnt0 != '1) set_cnt0_n = set_cnt0 + 1'b1;
          if (res_id && set_cnt1 != '1)  set_cnt1_n = set_cnt1 + 1'b1;
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cap         <= '0;
      win_id      <= 1'b0;
      last        <= 1'b1;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      res_valid   <= 1'b0;
      res_id      <= 1'b0;
      res_all_set <= 1'b0;
      set_cnt0    <= '0;
      set_cnt1    <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cap         <= cap_n;
      win_id      <= win_id_n;
      last        <= last_n;
      gnt0        <= gnt0_n;
      gnt1        <= gnt1_n;
      res_valid   <= res_valid_n;
      res_id      <= res_id_n;
      res_all_set <= res_all_set_n;
      set_cnt0    <= set_cnt0_n;
      set_cnt1    <= set_cnt1_n;
      busy        <= busy_n;
    end
  end

endmodule

// File: tb/tb_all_set_arbiter.sv
// Directed self-checking bench for all_set_arbiter; a second instance with a
// 2-bit counter covers saturation.
module tb_all_set_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, req0b;
  logic [7:0] data0, data1, data0b;
  logic       gnt0, gnt1, res_valid, res_id, res_all_set, busy;
  logic [7:0] set_cnt0, set_cnt1;
  logic       gnt0b, gnt1b, res_validb, res_idb, res_all_setb, busyb;
  logic [1:0] set_cnt0b, set_cnt1b;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  all_set_arbiter #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .res_valid(res_valid), .res_id(res_id),
    .res_all_set(res_all_set), .set_cnt0(set_cnt0), .set_cnt1(set_cnt1),
    .busy(busy)
  );

  all_set_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .req0(req0b), .data0(data0b), .req1(1'b0), .data1(8'h00),
    .gnt0(gnt0b), .gnt1(gnt1b), .res_valid(res_validb), .res_id(res_idb),
    .res_all_set(res_all_setb), .set_cnt0(set_cnt0b), .set_cnt1(set_cnt1b),
    .busy(busyb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the main instance, request dropped after capture.
  task automatic run_txn(input logic r0, input logic [7:0] d0, input logic r1,
                         input logic [7:0] d1, input logic exp_id, input logic exp_set);
    req0 = r0; data0 = d0; req1 = r1; data1 = d1;
    tick();
    check("gnt0", gnt0, !exp_id);
    check("gnt1", gnt1, exp_id);
    check("busy_chk", busy, 1'b1);
    check("rv_chk", res_valid, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    check("rv_done", res_valid, 1'b1);
    check("gnt_done", {gnt0, gnt1}, 2'b00);
    check("res_id", res_id, exp_id);
    check("res_all_set", res_all_set, exp_set);
    tick();
    check("rv_idle", res_valid, 1'b0);
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin
    logic [7:0] d1_vals [3];
    logic [1:0] sat_exp [5];
    d1_vals = '{8'hFE, 8'h00, 8'hC3};
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    req0b = 1'b0; data0b = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_gnt", {gnt0, gnt1}, 2'b00);
    check("rst_rv", res_valid, 1'b0);
    check("rst_id", res_id, 1'b0);
    check("rst_set", res_all_set, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cnt", {set_cnt0, set_cnt1}, 16'h0000);
    tick();
    check("idle_busy", busy, 1'b0);

    // single requester 0, all ones
    run_txn(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1);
    check("cnt0_after_ff", set_cnt0, 8'd1);

    // requester 1 alone, never all ones
    foreach (d1_vals[i]) run_txn(1'b0, 8'h00, 1'b1, d1_vals[i], 1'b1, 1'b0);
    check("cnt1_zero", set_cnt1, 8'd0);
    check("cnt0_kept", set_cnt0, 8'd1);

    // both held for 12 cycles after reset: strict alternation starting with 0
    rst = 1'b1; tick(); rst = 1'b0;
    req0 = 1'b1; data0 = 8'hFF; req1 = 1'b1; data1 = 8'hAA;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_gnt", {gnt1, gnt0}, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      check("rr_rv", res_valid, 1'b1);
      check("rr_id", res_id, k % 2);
      check("rr_set", res_all_set, (k % 2 == 0) ? 1'b1 : 1'b0);
      tick();
      check("rr_idle", {res_valid, gnt0, gnt1}, 3'b000);
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rr_cnt0", set_cnt0, 8'd2);
    check("rr_cnt1", set_cnt1, 8'd0);

    // reset during CHECK aborts the transaction
    rst = 1'b1; tick(); rst = 1'b0;
    req0 = 1'b1; data0 = 8'hFF;
    tick();
    check("abort_gnt", gnt0, 1'b1);
    req0 = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    check("abort_rv", res_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    tick();
    check("abort_rv2", res_valid, 1'b0);
    check("abort_cnt0", set_cnt0, 8'd0);
    check("abort_busy2", busy, 1'b0);

    // data change after capture does not affect the result
    req0 = 1'b1; data0 = 8'hFF;
    tick();
    req0 = 1'b0; data0 = 8'h00;
    tick();
    check("hold_rv", res_valid, 1'b1);
    check("hold_set", res_all_set, 1'b1);
    tick();
    check("hold_cnt0", set_cnt0, 8'd1);

    // almost-all-ones is not all set
    run_txn(1'b1, 8'h7F, 1'b0, 8'h00, 1'b0, 1'b0);
    check("cnt0_7f", set_cnt0, 8'd1);

    // 2-bit counter saturates
    for (int k = 0; k < 5; k++) begin
      req0b = 1'b1; data0b = 8'hFF;
      tick();
      req0b = 1'b0;
      tick(); tick();
      check("sat_cnt0", set_cnt0b, sat_exp[k]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
